// File: rtl/masked_sbox_layer_sequencer.sv
// Skinny-64 masked S-box layer sequencer: feeds 16 nibbles, one at a time, through a shared
// clock-gated HPC2 S-box. Optional watchdog enabled by defining MASKED_SBOX_SEQ_WATCHDOG_EN.
module masked_sbox_layer_sequencer #(
    parameter int unsigned NIBBLES = 16,
    parameter int unsigned SHARES  = 3,
    parameter int unsigned LATENCY = 5,
    parameter int unsigned FRESH_W = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [SHARES*4*NIBBLES-1:0]   state_in,
    output logic                          busy,
    output logic                          done,
    output logic [SHARES*4*NIBBLES-1:0]   state_out,
    input  logic                          rnd_valid,
    output logic                          rnd_ready,
    input  logic [FRESH_W-1:0]            rnd_data,
    output logic [SHARES*4-1:0]           sbox_x,
    output logic [FRESH_W-1:0]            sbox_fresh,
    output logic                          sbox_rst,
    input  logic [SHARES*4-1:0]           sbox_y,
    input  logic                          sbox_synch,
    output logic                          err
);

    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned CNT_W   = $clog2(LATENCY + 3);
    localparam int unsigned LAYER_W = 4 * NIBBLES;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
`ifdef MASKED_SBOX_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LATENCY + 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [CNT_W-1:0]          cnt;
    logic [SHARES*LAYER_W-1:0] state_q;
    logic [SHARES*4-1:0]       nib_in;
    logic                      sbox_rst_q;

    // Nibble idx of every share, kept share-separated.
    always_comb begin
        nib_in = '0;
        for (int unsigned s = 0; s < SHARES; s++) begin
            nib_in[s*4 +: 4] = state_q[s*LAYER_W + 4*32'(idx) +: 4];
        end
    end

    // rst feeds the gating controller directly so the S-box is held while rst is high.
    assign sbox_rst = sbox_rst_q | rst;

`ifdef MASKED_SBOX_SEQ_WATCHDOG_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rnd_ready  <= 1'b0;
            sbox_x     <= '0;
            sbox_fresh <= '0;
            sbox_rst_q <= 1'b0;
            state_out  <= '0;
            state_q    <= '0;
`ifdef MASKED_SBOX_SEQ_WATCHDOG_EN
            err_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= state_in;
                        idx       <= '0;
                        busy      <= 1'b1;
                        rnd_ready <= 1'b1;
                        state     <= S_FETCH;
`ifdef MASKED_SBOX_SEQ_WATCHDOG_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    // S-box inputs only move on an accepted word, so stalls hold them.
                    if (rnd_valid) begin
                        sbox_fresh <= rnd_data;
                        sbox_x     <= nib_in;
                        rnd_ready  <= 1'b0;
                        sbox_rst_q <= 1'b1;
                        state      <= S_ARM;
                    end
                end
                S_ARM: begin
                    sbox_rst_q <= 1'b0;
                    cnt        <= '0;
                    state      <= S_RUN;
                end
                S_RUN: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (sbox_synch) begin
                        for (int unsigned s = 0; s < SHARES; s++) begin
                            state_out[s*LAYER_W + 4*32'(idx) +: 4] <= sbox_y[s*4 +: 4];
                        end
                        if (idx == IDX_LAST) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx       <= idx + 1'b1;
                            rnd_ready <= 1'b1;
                            state     <= S_FETCH;
                        end
                    end
`ifdef MASKED_SBOX_SEQ_WATCHDOG_EN
                    else if (cnt == CNT_LIMIT) begin
                        err_q <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
`endif
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    rnd_ready <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    a_inputs_stable_in_run: assert property (@(posedge clk) disable iff (rst)
        (state == S_RUN) |-> ($stable(sbox_x) && $stable(sbox_fresh)));

    a_done_implies_busy: assert property (@(posedge clk) disable iff (rst)
        done |-> busy);

endmodule

// File: tb/tb_masked_sbox_layer_sequencer.sv
// Bench for masked_sbox_layer_sequencer: Skinny S-box model with random output masks,
// randomized PRNG words, reference layer computed nibble-wise on the unmasked value.
module tb_masked_sbox_layer_sequencer;

    localparam int NIBBLES   = 16;
    localparam int SHARES    = 3;
    localparam int LATENCY   = 5;
    localparam int FRESH_W   = 12;
    localparam int LAYER_CYC = 1 + NIBBLES * (LATENCY + 2);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [191:0] state_in = '0;
    logic         busy, done;
    logic [191:0] state_out;
    logic         rnd_valid = 1'b0;
    logic         rnd_ready;
    logic [11:0]  rnd_data = '0;
    logic [11:0]  sbox_x;
    logic [11:0]  sbox_fresh;
    logic         sbox_rst;
    logic [11:0]  sbox_y;
    logic         sbox_synch;
    logic         err;

    int checks = 0;
    int errors = 0;

    masked_sbox_layer_sequencer #(
        .NIBBLES(NIBBLES), .SHARES(SHARES), .LATENCY(LATENCY), .FRESH_W(FRESH_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in), .busy(busy), .done(done),
        .state_out(state_out), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .sbox_x(sbox_x), .sbox_fresh(sbox_fresh), .sbox_rst(sbox_rst), .sbox_y(sbox_y),
        .sbox_synch(sbox_synch), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox4(input logic [3:0] v);
        case (v)
            4'h0: return 4'hC; 4'h1: return 4'h6; 4'h2: return 4'h9; 4'h3: return 4'h0;
            4'h4: return 4'h1; 4'h5: return 4'hA; 4'h6: return 4'h2; 4'h7: return 4'hB;
            4'h8: return 4'h3; 4'h9: return 4'h8; 4'hA: return 4'h5; 4'hB: return 4'hD;
            4'hC: return 4'h4; 4'hD: return 4'hE; 4'hE: return 4'h7; default: return 4'hF;
        endcase
    endfunction

    function automatic logic [63:0] ref_layer(input logic [63:0] p);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox4(p[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] unshare(input logic [191:0] v);
        return v[63:0] ^ v[127:64] ^ v[191:128];
    endfunction

    // S-box model: Synch LATENCY cycles after sbox_rst drops, fresh output masks per evaluation,
    // junk on sbox_y outside the Synch cycle.
    logic       m_act = 1'b0;
    int         m_cnt = 0;
    logic [3:0] m1 = '0, m2 = '0;
    logic [11:0] junk = '0;
    logic       suppress_synch = 1'b0;

    always @(posedge clk) begin
        junk <= 12'($urandom);
        if (sbox_rst) begin
            m_act <= 1'b1;
            m_cnt <= 0;
            m1    <= 4'($urandom);
            m2    <= 4'($urandom);
        end else if (m_act) begin
            if (m_cnt == LATENCY - 1) m_act <= 1'b0;
            m_cnt <= m_cnt + 1;
        end
    end

    assign sbox_synch = m_act && !sbox_rst && (m_cnt == LATENCY - 1) && !suppress_synch;

    always_comb begin
        if (sbox_synch)
            sbox_y = {m2, m1, sbox4(sbox_x[3:0] ^ sbox_x[7:4] ^ sbox_x[11:8]) ^ m1 ^ m2};
        else
            sbox_y = junk;
    end

    // Observations from one layer run.
    logic [63:0] sh0, sh1, sh2;
    logic [11:0] fq[$];
    int          obs_done_cyc, obs_dones, obs_hs, obs_arms, obs_evals;
    int          obs_bad_hold, obs_bad_x, obs_bad_fresh, obs_bad_busy, obs_err;
    logic [63:0] obs_res, obs_res_late;
    logic        obs_busy_after;

    task automatic run_layer(input logic [63:0] plain, input int stall_nib, input int stall_len,
                             input int restart_a, input int restart_b);
        int          stalled;
        logic [11:0] prev_x, prev_f;
        logic        prev_hs;
        sh0 = {$urandom, $urandom};
        sh1 = {$urandom, $urandom};
        sh2 = plain ^ sh0 ^ sh1;
        fq.delete();
        obs_done_cyc = -1; obs_dones = 0; obs_hs = 0; obs_arms = 0; obs_evals = 0;
        obs_bad_hold = 0; obs_bad_x = 0; obs_bad_fresh = 0; obs_bad_busy = 0; obs_err = 0;
        obs_res = '0; obs_res_late = '0; obs_busy_after = 1'b1;
        stalled = 0;
        @(negedge clk);
        state_in  = {sh2, sh1, sh0};
        start     = 1'b1;
        rnd_valid = 1'b1;
        rnd_data  = 12'($urandom);
        prev_x    = sbox_x;
        prev_f    = sbox_fresh;
        prev_hs   = 1'b0;
        @(negedge clk);
        for (int cyc = 1; cyc <= LAYER_CYC + 80; cyc++) begin
            start    = (cyc == restart_a || cyc == restart_b);
            state_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (!prev_hs && (sbox_x !== prev_x || sbox_fresh !== prev_f)) obs_bad_hold++;
            prev_x = sbox_x;
            prev_f = sbox_fresh;
            if (sbox_rst === 1'b1) begin
                if (obs_arms >= 16 ||
                    sbox_x !== {sh2[4*obs_arms +: 4], sh1[4*obs_arms +: 4], sh0[4*obs_arms +: 4]})
                    obs_bad_x++;
                obs_arms++;
            end
            if (sbox_synch === 1'b1) begin
                if (obs_evals >= fq.size() || sbox_fresh !== fq[obs_evals]) obs_bad_fresh++;
                obs_evals++;
            end
            if (obs_dones == 0 && busy !== 1'b1) obs_bad_busy++;
            if (err !== 1'b0) obs_err++;
            if (done === 1'b1) begin
                obs_dones++;
                if (obs_dones == 1) begin
                    obs_done_cyc = cyc;
                    obs_res = unshare(state_out);
                end
            end
            if (obs_dones > 0 && cyc >= obs_done_cyc + 4) begin
                obs_busy_after = busy;
                obs_res_late   = unshare(state_out);
                break;
            end
            rnd_data = 12'($urandom);
            if (rnd_ready === 1'b1 && obs_hs == stall_nib && stalled < stall_len) begin
                rnd_valid = 1'b0;
                stalled++;
            end else begin
                rnd_valid = 1'b1;
            end
            prev_hs = rnd_valid && (rnd_ready === 1'b1);
            if (prev_hs) begin
                fq.push_back(rnd_data);
                obs_hs++;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        rnd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sbox_rst !== 1'b1) begin
            errors++; $display("FAIL reset_sbox_rst_high: got %b, expected 1", sbox_rst);
        end
        checks++;
        if ({busy, done, rnd_ready, err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got busy/done/ready/err=%b, expected 0000",
                               {busy, done, rnd_ready, err});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sbox_x !== 12'h000 || sbox_fresh !== 12'h000) begin
            errors++; $display("FAIL reset_sbox_inputs: got x=%h fresh=%h, expected 000 000",
                               sbox_x, sbox_fresh);
        end
        checks++;
        if (state_out !== 192'd0) begin
            errors++; $display("FAIL reset_state_out: got %h, expected 0", state_out);
        end
        checks++;
        if (sbox_rst !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: got sbox_rst=%b busy=%b, expected 0 0",
                               sbox_rst, busy);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_known_vector;
        logic [63:0] p;
        p = 64'h0123456789ABCDEF;
        run_layer(p, -1, 0, -1, -1);
        checks++;
        if (obs_done_cyc != LAYER_CYC) begin
            errors++; $display("FAIL kv_latency: got %0d, expected %0d", obs_done_cyc, LAYER_CYC);
        end
        checks++;
        if (obs_res !== ref_layer(p)) begin
            errors++; $display("FAIL kv_result: got %h, expected %h", obs_res, ref_layer(p));
        end
        checks++;
        if (obs_hs != 16 || obs_arms != 16 || obs_evals != 16) begin
            errors++; $display("FAIL kv_counts: got hs=%0d arms=%0d evals=%0d, expected 16 each",
                               obs_hs, obs_arms, obs_evals);
        end
        checks++;
        if (obs_bad_x != 0 || obs_bad_hold != 0 || obs_bad_fresh != 0) begin
            errors++; $display("FAIL kv_sbox_inputs: got bad_x=%0d bad_hold=%0d bad_fresh=%0d, expected 0",
                               obs_bad_x, obs_bad_hold, obs_bad_fresh);
        end
        checks++;
        if (obs_dones != 1 || obs_busy_after !== 1'b0 || obs_bad_busy != 0) begin
            errors++; $display("FAIL kv_handshake: got dones=%0d busy_after=%b bad_busy=%0d, expected 1 0 0",
                               obs_dones, obs_busy_after, obs_bad_busy);
        end
        checks++;
        if (obs_res_late !== ref_layer(p)) begin
            errors++; $display("FAIL kv_result_held: got %h, expected %h", obs_res_late, ref_layer(p));
        end
        checks++;
        if (obs_err != 0) begin
            errors++; $display("FAIL kv_err: got %0d err cycles, expected 0", obs_err);
        end
    endtask

    task automatic test_random_layers;
        logic [63:0] p;
        for (int n = 0; n < 3; n++) begin
            p = {$urandom, $urandom};
            run_layer(p, -1, 0, -1, -1);
            checks++;
            if (obs_res !== ref_layer(p) || obs_done_cyc != LAYER_CYC) begin
                errors++; $display("FAIL rand_layer%0d: got res=%h cyc=%0d, expected res=%h cyc=%0d",
                                   n, obs_res, obs_done_cyc, ref_layer(p), LAYER_CYC);
            end
            checks++;
            if (obs_bad_fresh != 0 || obs_bad_x != 0 || obs_hs != 16) begin
                errors++; $display("FAIL rand_inputs%0d: got bad_fresh=%0d bad_x=%0d hs=%0d, expected 0 0 16",
                                   n, obs_bad_fresh, obs_bad_x, obs_hs);
            end
        end
    endtask

    task automatic test_prng_stall;
        logic [63:0] p;
        p = {$urandom, $urandom};
        run_layer(p, 7, 10, -1, -1);
        checks++;
        if (obs_done_cyc != LAYER_CYC + 10) begin
            errors++; $display("FAIL stall_latency: got %0d, expected %0d", obs_done_cyc, LAYER_CYC + 10);
        end
        checks++;
        if (obs_bad_hold != 0) begin
            errors++; $display("FAIL stall_hold: got %0d input changes, expected 0", obs_bad_hold);
        end
        checks++;
        if (obs_res !== ref_layer(p) || obs_bad_fresh != 0 || obs_hs != 16) begin
            errors++; $display("FAIL stall_result: got %h bad_fresh=%0d hs=%0d, expected %h 0 16",
                               obs_res, obs_bad_fresh, obs_hs, ref_layer(p));
        end
    endtask

    task automatic test_start_ignored;
        logic [63:0] p;
        p = {$urandom, $urandom};
        run_layer(p, -1, 0, 5, 60);
        checks++;
        if (obs_dones != 1 || obs_done_cyc != LAYER_CYC) begin
            errors++; $display("FAIL restart_done: got dones=%0d cyc=%0d, expected 1 %0d",
                               obs_dones, obs_done_cyc, LAYER_CYC);
        end
        checks++;
        if (obs_res !== ref_layer(p) || obs_busy_after !== 1'b0) begin
            errors++; $display("FAIL restart_result: got %h busy_after=%b, expected %h 0",
                               obs_res, obs_busy_after, ref_layer(p));
        end
    endtask

    task automatic test_reset_mid_layer;
        int          n_done;
        int          n_busy;
        logic [63:0] p;
        @(negedge clk);
        state_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start     = 1'b1;
        rnd_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 40; c++) begin
            rnd_data = 12'($urandom);
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midrst_busy_before: got %b, expected 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sbox_rst !== 1'b1) begin
            errors++; $display("FAIL midrst_sbox_rst: got %b, expected 1", sbox_rst);
        end
        @(negedge clk);
        rst = 1'b0;
        rnd_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rnd_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_abort: got busy=%b done=%b ready=%b, expected 0 0 0",
                               busy, done, rnd_ready);
        end
        n_done = 0;
        n_busy = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (busy !== 1'b0) n_busy++;
        end
        checks++;
        if (n_done != 0 || n_busy != 0) begin
            errors++; $display("FAIL midrst_quiet: got dones=%0d busy_cycles=%0d, expected 0 0",
                               n_done, n_busy);
        end
        p = {$urandom, $urandom};
        run_layer(p, -1, 0, -1, -1);
        checks++;
        if (obs_done_cyc != LAYER_CYC || obs_res !== ref_layer(p)) begin
            errors++; $display("FAIL midrst_next_layer: got cyc=%0d res=%h, expected %0d %h",
                               obs_done_cyc, obs_res, LAYER_CYC, ref_layer(p));
        end
    endtask

`ifdef MASKED_SBOX_SEQ_WATCHDOG_EN
    task automatic test_watchdog;
        int          hs;
        int          err_cyc;
        int          n_done;
        int          exp_cyc;
        logic [63:0] p;
        // nibble 3 fetch, arm, LATENCY+2 RUN cycles counted from 0, then the error cycle
        exp_cyc = 1 + 3 * (LATENCY + 2) + 2 + (LATENCY + 2) + 1;
        hs = 0; err_cyc = -1; n_done = 0;
        @(negedge clk);
        state_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start     = 1'b1;
        rnd_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (done === 1'b1) n_done++;
            if (err === 1'b1) begin
                err_cyc = cyc;
                break;
            end
            rnd_data = 12'($urandom);
            if (rnd_ready === 1'b1) begin
                hs++;
                if (hs == 4) suppress_synch = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (err_cyc != exp_cyc) begin
            errors++; $display("FAIL wd_err_cycle: got %0d, expected %0d", err_cyc, exp_cyc);
        end
        checks++;
        if (busy !== 1'b0 || n_done != 0) begin
            errors++; $display("FAIL wd_abort: got busy=%b dones=%0d, expected 0 0", busy, n_done);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL wd_sticky: got err=%b done=%b, expected 1 0", err, done);
        end
        suppress_synch = 1'b0;
        rnd_valid = 1'b0;
        p = {$urandom, $urandom};
        run_layer(p, -1, 0, -1, -1);
        checks++;
        if (obs_err != 0 || obs_res !== ref_layer(p) || obs_done_cyc != LAYER_CYC) begin
            errors++; $display("FAIL wd_recover: got err_cycles=%0d res=%h cyc=%0d, expected 0 %h %0d",
                               obs_err, obs_res, obs_done_cyc, ref_layer(p), LAYER_CYC);
        end
    endtask
`else
    task automatic test_no_watchdog;
        int hs;
        int n_done;
        int n_err;
        hs = 0; n_done = 0; n_err = 0;
        @(negedge clk);
        state_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start     = 1'b1;
        rnd_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 80; cyc++) begin
            if (done === 1'b1) n_done++;
            if (err !== 1'b0) n_err++;
            rnd_data = 12'($urandom);
            if (rnd_ready === 1'b1) begin
                hs++;
                if (hs == 4) suppress_synch = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b1 || n_done != 0 || n_err != 0 || hs != 4) begin
            errors++; $display("FAIL nowd_wait: got busy=%b dones=%0d err_cycles=%0d hs=%0d, expected 1 0 0 4",
                               busy, n_done, n_err, hs);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rnd_valid = 1'b0;
        suppress_synch = 1'b0;
        repeat (20) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_known_vector();
        test_random_layers();
        test_prng_stall();
        test_start_ignored();
        test_reset_mid_layer();
`ifdef MASKED_SBOX_SEQ_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
